// File: rtl/mac_pkg.sv
// Shared MAC result-RAM geometry and the result-reader state encoding.
// Used by the MAC array, the result RAM and the reader, so all three agree on widths.
package mac_pkg;
  localparam int RES_W      = 19;
  localparam int RES_ADDR_W = 6;
  localparam int RES_DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_t;
endpackage

// File: rtl/mac_result_reader_if.sv
// Valid/ready word stream from the result reader toward host egress.
// Master drives data/valid/last; slave drives ready.
interface mac_result_reader_if import mac_pkg::*; #(parameter int DW = RES_W) ();
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/mac_result_reader_pair_fifo.sv
// Sync FIFO, two-word push / one-word pop, first-word fall-through output.
// Zero-latency read of the head; the writer must hold credit so a push never overflows.
module pair_fifo #(
  parameter int DW    = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            din1,
  input  logic [DW-1:0]            din2,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // din1 lands first so the even word leaves ahead of its odd partner
      if (push) begin
        mem[wr_ptr]          <= din1;
        mem[wr_ptr + PW'(1)] <= din2;
        wr_ptr               <= wr_ptr + PW'(2);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (push ? CW'(2) : CW'(0)) - (do_pop ? CW'(1) : CW'(0));
    end
  end
endmodule

// File: rtl/mac_result_reader.sv
// Drains the MAC result RAM as address pairs into a small FIFO and streams words 0..DEPTH-1.
// Start-to-first-valid is 3 cycles; credit on FIFO space stops issuing so m_ready stalls never drop data.
module mac_result_reader
  import mac_pkg::*;
#(
  parameter int DW         = RES_W,
  parameter int ADDR_W     = RES_ADDR_W,
  parameter int DEPTH      = RES_DEPTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   ram_addr1,
  output logic [ADDR_W-1:0]   ram_addr2,
  input  logic [DW-1:0]       ram_dout1,
  input  logic [DW-1:0]       ram_dout2,
  mac_result_reader_if.master m,
  output logic [ADDR_W:0]     word_count
);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int KW  = ADDR_W - 1;
  localparam logic [KW-1:0]   LAST_PAIR = KW'(DEPTH / 2 - 1);
  localparam logic [ADDR_W:0] WC_MAX    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] WC_LAST   = (ADDR_W + 1)'(DEPTH - 1);

  rd_state_t        state;
  logic [KW-1:0]    pair_k;
  logic             inflight;
  logic [FCW-1:0]   fifo_count;
  logic [FCW:0]     reserved;
  logic [DW-1:0]    fifo_dout;
  logic             issue;
  logic             pop;

  assign ram_addr1 = {pair_k, 1'b0};
  assign ram_addr2 = {pair_k, 1'b1};

  // Words already queued plus the pair still coming back from the RAM
  assign reserved = {1'b0, fifo_count} + (inflight ? (FCW + 1)'(2) : (FCW + 1)'(0));
  assign issue    = (state == READ) && (reserved <= (FCW + 1)'(FIFO_DEPTH - 2));

  assign m.data  = fifo_dout;
  assign m.valid = (fifo_count != '0);
  assign m.last  = m.valid && (word_count == WC_LAST);
  assign pop     = m.valid && m.ready;

  pair_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .din1  (ram_dout1),
    .din2  (ram_dout2),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pair_k     <= '0;
      inflight   <= 1'b0;
      word_count <= '0;
    end else begin
      inflight <= issue;
      if (pop && (word_count != WC_MAX)) word_count <= word_count + (ADDR_W + 1)'(1);
      case (state)
        IDLE: begin
          if (start) begin
            state      <= READ;
            busy       <= 1'b1;
            pair_k     <= '0;
            word_count <= '0;
          end
        end
        READ: begin
          if (issue) begin
            if (pair_k == LAST_PAIR) state <= DRAIN;
            else                     pair_k <= pair_k + KW'(1);
          end
        end
        DRAIN: begin
          // done is held for one cycle with busy still high, then we release
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (pop && m.last) begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_result_reader.sv
// Bench for mac_result_reader: RAM model, directed ready/start/reset scenarios,
// and a per-cycle stream monitor checking order, stability, count and timing.
module tb_mac_result_reader;
  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [5:0]  ram_addr1;
  logic [5:0]  ram_addr2;
  logic [18:0] ram_dout1;
  logic [18:0] ram_dout2;
  logic [6:0]  word_count;

  mac_result_reader_if #(.DW(19)) m_if ();

  mac_result_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .ram_addr1  (ram_addr1),
    .ram_addr2  (ram_addr2),
    .ram_dout1  (ram_dout1),
    .ram_dout2  (ram_dout2),
    .m          (m_if),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [18:0] ram [64];
  always @(posedge clk) begin
    ram_dout1 <= ram[ram_addr1];
    ram_dout2 <= ram[ram_addr2];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected stream is simply ram[0..63] in order, one word per accepted transfer
  bit          mon_en = 1'b0;
  int          start_cyc = 0;
  int          mrel;
  int          exp_idx, first_valid_rel, last_rel, done_rel, busy_low_rel;
  int          done_cnt = 0;
  bit          prev_stall, busy_at_done;
  logic [18:0] prev_data;
  int          got [64];

  always @(negedge clk) begin
    if (!mon_en) begin
      exp_idx = 0; first_valid_rel = -1; last_rel = -1; done_rel = -1;
      busy_low_rel = -1; prev_stall = 1'b0; busy_at_done = 1'b0;
    end else begin
      mrel = cyc - start_cyc;
      if (m_if.valid) begin
        if (first_valid_rel < 0) first_valid_rel = mrel;
        if (exp_idx < 64) begin
          chk("stream_data", longint'($signed(m_if.data)), longint'(ram[exp_idx]));
          chk("stream_last", longint'(m_if.last), (exp_idx == 63) ? 1 : 0);
        end else begin
          chk("extra_word_index", exp_idx, 63);
        end
      end else begin
        chk("last_without_valid", longint'(m_if.last), 0);
      end
      if (prev_stall) begin
        chk("stall_valid_held", longint'(m_if.valid), 1);
        chk("stall_data_held", longint'(m_if.data), longint'(prev_data));
      end
      chk("word_count", longint'(word_count), exp_idx);
      chk("fifo_occ_le_4", (dut.u_fifo.count <= 4) ? 1 : 0, 1);
      if (done) begin
        done_cnt++;
        done_rel = mrel;
        busy_at_done = busy;
        chk("done_after_all_words", exp_idx, 64);
      end
      if (!busy && busy_low_rel < 0) busy_low_rel = mrel;
      if (m_if.valid && m_if.last) last_rel = mrel;
      prev_stall = m_if.valid && !m_if.ready;
      prev_data  = m_if.data;
      if (m_if.valid && m_if.ready) begin
        if (exp_idx < 64) got[exp_idx] = int'($signed(m_if.data));
        exp_idx++;
      end
    end
  end

  task automatic check_reset_values();
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_m_valid", longint'(m_if.valid), 0);
    chk("rst_m_last", longint'(m_if.last), 0);
    chk("rst_m_data", longint'(m_if.data), 0);
    chk("rst_addr1", longint'(ram_addr1), 0);
    chk("rst_addr2", longint'(ram_addr2), 1);
    chk("rst_word_count", longint'(word_count), 0);
  endtask

  // mode 0: ready=1; 1: ready 1,0,0,1 repeating; 2: ready=0 for 20 cycles;
  // 3: ready=1 with a second start during READ; 4: reset at cycle 30
  function automatic logic rdy(input int mode, input int rel);
    case (mode)
      1:       return (rel % 4 == 1) || (rel % 4 == 0);
      2:       return rel > 20;
      default: return 1'b1;
    endcase
  endfunction

  task automatic run(input int mode);
    int d0;
    bit fin;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    m_if.ready = 1'b0;
    fin = 1'b0;
    for (int rel = 1; rel <= 400 && !fin; rel++) begin
      @(posedge clk); #1;
      start = (mode == 3 && rel == 5);
      mon_en = (mode != 4) || (rel < 30);
      m_if.ready = rdy(mode, rel);
      if (mode == 4 && rel == 30) reset = 1'b1;
      if (mode == 4 && rel == 31) begin
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();
        fin = 1'b1;
      end
      if (mode == 2 && rel == 20) begin
        @(negedge clk);
        chk("stall_fifo_full", longint'(dut.u_fifo.count), 4);
        chk("stall_addr1_held", longint'(ram_addr1), 4);
        chk("stall_addr2_held", longint'(ram_addr2), 5);
        chk("stall_valid", longint'(m_if.valid), 1);
      end
      if (done_rel >= 0 && rel > done_rel + 1) fin = 1'b1;
    end
    if (mode != 4) begin
      chk("done_exactly_once", done_cnt - d0, 1);
      chk("words_delivered", exp_idx, 64);
      chk("word_count_end", longint'(word_count), 64);
      chk("busy_with_done", longint'(busy_at_done), 1);
      if (mode == 0) begin
        chk("first_valid_cycle", first_valid_rel, 3);
        chk("last_cycle", last_rel, 66);
        chk("done_cycle", done_rel, 67);
        chk("busy_low_cycle", busy_low_rel, 68);
      end
    end
    start = 1'b0;
    mon_en = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 64; i++) ram[i] = 19'(1000 * i - 32000);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    m_if.ready = 1'b0;
    load_ramp();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    reset = 1'b0;

    run(0);
    chk("ramp_word0", got[0], -32000);
    chk("ramp_word32", got[32], 0);
    chk("ramp_word63", got[63], 31000);

    ram[0] = -19'sd262144;
    ram[1] = 19'sd262143;
    run(0);
    chk("extreme_min", got[0], -262144);
    chk("extreme_max", got[1], 262143);
    load_ramp();

    run(1);
    run(2);
    run(4);
    run(0);
    chk("after_reset_word0", got[0], -32000);
    run(3);
    chk("restart_ignored_word63", got[63], 31000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mac_result_reader.md
# mac_result_reader

Drains the 64-entry, 19-bit signed result RAM written by the 8-lane MAC array and streams its contents out as a valid/ready word stream, in address order 0..63. It drives both read ports of the result RAM to fetch address pairs (2k, 2k+1) and buffers the returned data in a small FIFO. The FIFO absorbs downstream backpressure without losing data. It sits between the MAC array's `done` and the host/UART egress path.

## Interface
- `DW`, 19, result word width (signed two's complement)
- `ADDR_W`, 6, result RAM address width
- `DEPTH`, 64, number of words drained per run (even, ≤ 2^ADDR_W)
- `FIFO_DEPTH`, 4, output FIFO entries (≥ 4, power of two)

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  begin drain; sampled only in IDLE
- `busy`  out  1  high from cycle after accepted start until done pulse
- `done`  out  1  one-cycle pulse after last word accepted
- `ram_addr1`  out  ADDR_W  result RAM port-1 address (even words)
- `ram_addr2`  out  ADDR_W  result RAM port-2 address (odd words)
- `ram_dout1`  in  DW  port-1 read data, one-cycle synchronous read latency
- `ram_dout2`  in  DW  port-2 read data, one-cycle latency
- `m_data`  out  DW  stream data
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  stream ready
- `m_last`  out  1  high with word DEPTH-1
- `word_count`  out  ADDR_W+1  words accepted downstream this run

## Operation
- States: IDLE, READ, DRAIN.
- IDLE → READ on `start`; pair counter k=0, `word_count`=0. `start` in READ/DRAIN is ignored.
- READ: issues pair k (addr1=2k, addr2=2k+1) in a cycle when credit allows.
  - Credit: FIFO_DEPTH − occupancy − 2·inflight ≥ 2.
  - Inflight is 0 or 1 pair.
  - Addresses hold when the block is not issuing.
- Returned pair is pushed in the following cycle, port 1 word first. A simultaneous push and pop is legal.
- After pair DEPTH/2−1 issues → DRAIN.
- DRAIN: waits for the FIFO to empty and the `m_last` word to be accepted, then pulses `done` and returns to IDLE.
- Handshake: a word transfers when `m_valid`&&`m_ready`.
  - `m_data`/`m_valid`/`m_last` are stable while `m_valid` && !`m_ready`.
  - `m_valid` never drops without a transfer.
- Data passes unmodified: no truncation or sign change.
- `word_count` increments per transfer and saturates at DEPTH.
- Reset at any time, mid-run included: FIFO flushed, inflight data discarded, state IDLE.
- Reset values:
  - `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0
  - `ram_addr1`=0, `ram_addr2`=1, `word_count`=0

## Timing
- Cycle 0: `start`=1 in IDLE.
- Cycle 1: READ, `busy`=1, pair 0 issued.
- Cycle 2: data returned and pushed.
- Cycle 3: `m_valid`=1 with word 0. Start-to-first-valid latency is 3 cycles.
- Throughput 1 word/cycle with `m_ready` held high; a pair is issued every other cycle in steady state.
- With `m_ready`=1 continuously: `m_last` in cycle 66, `done` in cycle 67, `busy` low in cycle 68. `start` is accepted again in cycle 68.
- No FIFO overflow under any `m_ready` pattern, guaranteed by credit.

## Structure
- Shared package `mac_pkg` holds:
  - `RES_W`=19, `RES_ADDR_W`=6, `RES_DEPTH`=64 (shared with the MAC array and result RAM)
  - the state enum `rd_state_t` {IDLE, READ, DRAIN}
- One sub-module, `pair_fifo`:
  - synchronous FIFO with dual-word push (two words per cycle) and single-word pop
  - exposes `count`; first-word fall-through output.
- Top level holds the FSM, pair counter, credit logic and `word_count`.

## Test plan
- Result RAM preloaded with c[i] = 1000·i − 32000, `m_ready`=1 → 64 words in order.
  - Word 0 = −32000 at cycle 3; word 63 = 31000 with `m_last` at cycle 66; `done` at cycle 67.
- Extremes c[0]=−262144, c[1]=262143 → output exactly −262144 and 262143, with no sign corruption.
- `m_ready` toggling 1,0,0,1 pattern → all 64 words delivered once, in order, with stable data during stalls.
  - FIFO occupancy never exceeds 4; `word_count` ends at 64.
- `m_ready`=0 for 20 cycles after start → FIFO fills to 4 and issuing stops.
  - Release → words 0..63 intact; `done` exactly once.
- `reset` asserted at cycle 30 mid-run → next cycle `m_valid`=0, `busy`=0, addresses 0/1.
  - A new `start` then delivers word 0 first.
- `start` pulsed again during READ → ignored; exactly 64 words and one `done`.
